// File: rtl/clkdiv_edge_monitor_pkg.sv
// clkdiv_edge_monitor_pkg: shared state encoding and defaults for divider-related blocks
package clkdiv_edge_monitor_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEAS, LOCKED} state_e;
  localparam int DIV_CNT_W   = 8;
  localparam int DIV_TIMEOUT = 255;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser with history flop producing rise/fall strobes
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end
  assign rise = sync_q[SYNC_STAGES-1] & ~hist;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist;
endmodule

// File: rtl/clkdiv_edge_monitor.sv
// clkdiv_edge_monitor: turns a divided clock into enable pulses and checks its period
module clkdiv_edge_monitor
  import clkdiv_edge_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DIV_CNT_W,
  parameter int TIMEOUT     = DIV_TIMEOUT,
  parameter int LOCK_CNT    = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_div,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_period,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             mismatch,
  output logic             locked,
  output logic             stuck
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  logic rise, fall, match, timeout;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [MW-1:0] match_cnt;
  state_e state;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rstn(rstn),
    .din (clk_div),
    .rise(rise),
    .fall(fall)
  );
  // periods of 0 or 1 are never legal, so they must never match
  assign match   = (exp_period > CNT_W'(1)) && (cnt == exp_period);
  assign timeout = !rise && (cnt >= TO);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      match_cnt  <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      mismatch   <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      rise_pulse <= en & rise;
      fall_pulse <= en & fall;
      period_vld <= 1'b0;
      mismatch   <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
        stuck     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
          end
          ARM: begin
            cnt <= rise ? CNT_W'(1) : cnt_inc;
            if (rise) begin
              state <= MEAS;
              stuck <= 1'b0;
            end else if (timeout) begin
              stuck <= 1'b1;
            end
          end
          MEAS, LOCKED: begin
            cnt <= rise ? CNT_W'(1) : cnt_inc;
            if (rise) begin
              period     <= cnt;
              period_vld <= 1'b1;
              if (match) begin
                match_cnt <= (match_cnt == MW'(LOCK_CNT)) ? match_cnt : match_cnt + MW'(1);
                if (state == MEAS && match_cnt == MW'(LOCK_CNT - 1)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                state     <= MEAS;
                mismatch  <= 1'b1;
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end else if (timeout) begin
              state     <= ARM;
              stuck     <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
            end
          end
        endcase
      end
    end
  end
endmodule
